// File: rtl/riscv_core_icache_nway.sv
// riscv_core_icache_nway: N-way set-associative I-cache with per-set round-robin refill,
// a fence.i invalidate walk and hit/miss counters.
module riscv_core_icache_nway #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CORE_DATA_WIDTH = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int NUM_SETS        = 128,
    parameter int NUM_WAYS        = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req,
    input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
    input  logic                       i_flush,
    output logic                       o_stall,
    output logic [CORE_DATA_WIDTH-1:0] o_data_to_core,
    output logic [ADDR_WIDTH-1:0]      o_addr_from_control_to_axi,
    output logic                       o_mem_req,
    input  logic                       i_mem_done,
    input  logic [AXI_DATA_WIDTH-1:0]  i_block_from_axi,
    output logic [31:0]                o_hit_cnt,
    output logic [31:0]                o_miss_cnt
);
    localparam int OFFSET_BITS = $clog2(AXI_DATA_WIDTH / 8);
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int WSEL_BITS   = OFFSET_BITS - 2;
    localparam int WAY_BITS    = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_e;

    logic [NUM_WAYS-1:0]       valid_q [NUM_SETS];
    logic [TAG_BITS-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
    logic [AXI_DATA_WIDTH-1:0] line_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_BITS-1:0]       ptr_q   [NUM_SETS];

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [WAY_BITS-1:0]     victim_q, victim_d;
    logic                    pend_q, pend_d;
    logic [INDEX_BITS-1:0]   fcnt_q, fcnt_d;
    logic                    mem_req_q;
    logic [31:0]             hit_cnt_q, miss_cnt_q;

    logic [TAG_BITS-1:0]       tag_in;
    logic [INDEX_BITS-1:0]     idx_in;
    logic [WSEL_BITS-1:0]      wsel_in;
    logic                      hit;
    logic [WAY_BITS-1:0]       hit_way;
    logic [WAY_BITS-1:0]       victim;
    logic [AXI_DATA_WIDTH-1:0] hit_line;
    logic                      hit_inc, miss_inc, refill_wr;
    logic                      unused_addr_lsb;

    assign tag_in          = i_addr_from_core[ADDR_WIDTH-1 -: TAG_BITS];
    assign idx_in          = i_addr_from_core[OFFSET_BITS +: INDEX_BITS];
    assign wsel_in         = i_addr_from_core[OFFSET_BITS-1:2];
    assign unused_addr_lsb = ^i_addr_from_core[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (valid_q[idx_in][w] && tag_q[idx_in][w] == tag_in) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
    end

    // Lowest invalid way wins; a full set falls back to its round-robin pointer.
    always_comb begin
        victim = ptr_q[idx_in];
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!valid_q[idx_in][w]) victim = WAY_BITS'(w);
    end

    assign hit_line       = line_q[idx_in][hit_way];
    assign o_data_to_core = hit ? hit_line[wsel_in*CORE_DATA_WIDTH +: CORE_DATA_WIDTH] : '0;
    assign o_stall        = (state_q != IDLE) || i_flush || (i_req && !hit);
    assign o_mem_req      = mem_req_q;
    assign o_addr_from_control_to_axi = addr_q;
    assign o_hit_cnt      = hit_cnt_q;
    assign o_miss_cnt     = miss_cnt_q;
    assign refill_wr      = (state_q == REFILL) && i_mem_done;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        victim_d = victim_q;
        pend_d   = pend_q;
        fcnt_d   = fcnt_q;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_flush) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end else if (i_req && hit) begin
                    hit_inc = 1'b1;
                end else if (i_req) begin
                    addr_d   = {i_addr_from_core[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    idx_d    = idx_in;
                    victim_d = victim;
                    miss_inc = 1'b1;
                    state_d  = REFILL;
                end
            end
            REFILL: begin
                pend_d = pend_q | i_flush;
                if (i_mem_done) begin
                    state_d = (pend_q || i_flush) ? FLUSH : IDLE;
                    pend_d  = 1'b0;
                    fcnt_d  = '0;
                end
            end
            FLUSH: begin
                fcnt_d  = fcnt_q + 1'b1;
                state_d = (fcnt_q == INDEX_BITS'(NUM_SETS - 1)) ? IDLE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            idx_q      <= '0;
            victim_q   <= '0;
            pend_q     <= 1'b0;
            fcnt_q     <= '0;
            mem_req_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            victim_q   <= victim_d;
            pend_q     <= pend_d;
            fcnt_q     <= fcnt_d;
            mem_req_q  <= state_d == REFILL;
            hit_cnt_q  <= hit_cnt_q + 32'(hit_inc);
            miss_cnt_q <= miss_cnt_q + 32'(miss_inc);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (refill_wr) begin
            valid_q[idx_q][victim_q] <= 1'b1;
            if (victim_q == ptr_q[idx_q])
                ptr_q[idx_q] <= (NUM_WAYS == 1) ? '0 : ptr_q[idx_q] + 1'b1;
        end else if (state_q == FLUSH) begin
            valid_q[fcnt_q] <= '0;
            ptr_q[fcnt_q]   <= '0;
        end
    end

    // Tag and line payload need no reset: they are qualified by the valid bits.
    always_ff @(posedge i_clk) begin
        if (refill_wr) begin
            tag_q[idx_q][victim_q]  <= addr_q[ADDR_WIDTH-1 -: TAG_BITS];
            line_q[idx_q][victim_q] <= i_block_from_axi;
        end
    end
endmodule

// File: tb/tb_riscv_core_icache_nway.sv
// tb_riscv_core_icache_nway: directed and randomized fetches against a
// set/way reference model of the cache, including flush and reset cases.
module tb_riscv_core_icache_nway;
    localparam int NS  = 128;
    localparam int NW  = 2;
    localparam int LW  = 256;
    localparam int OFF = 5;
    localparam int IDX = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic [31:0]   addr = '0;
    logic          flush = 1'b0;
    logic          done = 1'b0;
    logic [LW-1:0] block = '0;
    logic          stall, mem_req;
    logic [31:0]   rdata, axi_addr, hit_cnt, miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit            m_valid [NS][NW];
    int unsigned   m_tag   [NS][NW];
    logic [LW-1:0] m_line  [NS][NW];
    int            m_ptr   [NS];
    int unsigned   m_hits, m_misses;

    riscv_core_icache_nway dut (
        .i_clk                      (clk),
        .i_rst_n                    (rst_n),
        .i_req                      (req),
        .i_addr_from_core           (addr),
        .i_flush                    (flush),
        .o_stall                    (stall),
        .o_data_to_core             (rdata),
        .o_addr_from_control_to_axi (axi_addr),
        .o_mem_req                  (mem_req),
        .i_mem_done                 (done),
        .i_block_from_axi           (block),
        .o_hit_cnt                  (hit_cnt),
        .o_miss_cnt                 (miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> OFF) % NS);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a >> (OFF + IDX);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % (LW / 32));
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic bit model_lookup(input logic [31:0] a, output int way);
        int s = set_of(a);
        way = 0;
        for (int w = 0; w < NW; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) begin
                way = w;
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic int model_victim(input int s);
        for (int w = 0; w < NW; w++)
            if (!m_valid[s][w]) return w;
        return m_ptr[s];
    endfunction

    function automatic void model_fill(input int s, input int w, input int unsigned t, input logic [LW-1:0] l);
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = t;
        m_line[s][w]  = l;
        if (w == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % NW;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < NS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        model_flush();
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Called at negedge+1 of a cycle that must stall; counts the stall run.
    task automatic count_stall(input string tag, input int exp);
        int n = 0;
        while (stall && n < exp + 4) begin
            n++;
            @(posedge clk);
            @(negedge clk);
            req   = 1'b0;
            flush = (n == 5);
            #1;
        end
        flush = 1'b0;
        check(tag, n, exp);
    endtask

    task automatic flush_idle(input bit with_req);
        @(negedge clk);
        flush = 1'b1;
        req   = with_req;
        addr  = $urandom;
        #1;
        model_flush();
        count_stall("flush_len", NS + 1);
    endtask

    task automatic fetch(input logic [31:0] a, input int delay, input int flush_at,
                         input bit set_w1, output bit was_hit);
        int            way, s, v;
        bit            mh;
        logic [LW-1:0] line;
        s = set_of(a);
        @(negedge clk);
        req   = 1'b1;
        addr  = a;
        flush = 1'b0;
        #1;
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
        mh      = model_lookup(a, way);
        was_hit = !stall;
        check("stall_lookup", stall, 32'(!mh));
        if (mh) begin
            check("hit_data", rdata, m_line[s][way][word_of(a)*32 +: 32]);
            m_hits++;
            @(posedge clk);
        end else begin
            check("miss_data", rdata, 0);
            v    = model_victim(s);
            line = rand_line();
            if (set_w1) line[63:32] = 32'hDEADBEEF;
            m_misses++;
            @(posedge clk);
            for (int c = 0; c <= delay; c++) begin
                @(negedge clk);
                addr  = (c == delay) ? a : $urandom;
                flush = (c == flush_at);
                #1;
                check("mem_req", mem_req, 1);
                check("axi_addr", axi_addr, a & ~32'(LW / 8 - 1));
                check("stall_refill", stall, 1);
                if (c == delay) begin
                    done  = 1'b1;
                    block = line;
                end
            end
            @(posedge clk);
            model_fill(s, v, tag_of(a), line);
            @(negedge clk);
            done  = 1'b0;
            block = '0;
            flush = 1'b0;
            if (flush_at >= 0 && flush_at <= delay) begin
                req = 1'b0;
                #1;
                check("mem_req_drop", mem_req, 0);
                model_flush();
                count_stall("refill_flush_len", NS);
            end else begin
                #1;
                check("mem_req_drop", mem_req, 0);
                check("refill_stall", stall, 0);
                check("refill_data", rdata, line[word_of(a)*32 +: 32]);
                m_hits++;
                @(posedge clk);
            end
        end
    endtask

    initial begin
        bit wh;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_axi_addr", axi_addr, 0);
        check("rst_data", rdata, 0);
        check("rst_hits", hit_cnt, 0);
        check("rst_misses", miss_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fetch(32'h0000_1004, 0, -1, 1'b1, wh);
        check("cold_was_hit", wh, 0);
        @(negedge clk);
        req  = 1'b1;
        addr = 32'h0000_1004;
        #1;
        check("cold_word1", rdata, 32'hDEADBEEF);
        check("cold_hits", hit_cnt, 1);
        check("cold_misses", miss_cnt, 1);
        @(posedge clk);
        m_hits++;

        fetch(32'h0000_1000, 0, -1, 1'b0, wh);
        check("hitpath_0", wh, 1);
        fetch(32'h0000_1008, 0, -1, 1'b0, wh);
        check("hitpath_2", wh, 1);
        fetch(32'h0000_101C, 0, -1, 1'b0, wh);
        check("hitpath_7", wh, 1);

        fetch(32'h0001_1000, 1, -1, 1'b0, wh);
        check("conf_fill1", wh, 0);
        fetch(32'h0002_1000, 2, -1, 1'b0, wh);
        check("conf_fill2", wh, 0);
        fetch(32'h0000_1000, 0, -1, 1'b0, wh);
        check("rr_evict_way0", wh, 0);
        fetch(32'h0002_1000, 0, -1, 1'b0, wh);
        check("rr_keep", wh, 1);
        fetch(32'h0001_1000, 0, -1, 1'b0, wh);
        check("rr_evict_way1", wh, 0);

        flush_idle(1'b1);
        fetch(32'h0000_1000, 0, -1, 1'b0, wh);
        check("post_flush_a", wh, 0);
        fetch(32'h0001_1000, 0, -1, 1'b0, wh);
        check("post_flush_b", wh, 0);

        fetch(32'h0000_3040, 4, 2, 1'b0, wh);
        check("fdr_first", wh, 0);
        fetch(32'h0000_3040, 0, -1, 1'b0, wh);
        check("fdr_refetch", wh, 0);

        @(negedge clk);
        req  = 1'b1;
        addr = 32'h0000_5000;
        #1;
        check("rmr_lookup", stall, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rmr_mem_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("rmr_mem_req_drop", mem_req, 0);
        check("rmr_hits", hit_cnt, 0);
        check("rmr_misses", miss_cnt, 0);
        check("rmr_stall", stall, 1);
        model_reset();
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b1;
        fetch(32'h0000_5000, 1, -1, 1'b0, wh);
        check("rmr_refetch", wh, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 5) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) flush_idle(1'($urandom_range(0, 1)));
            fetch(a, $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b0, wh);
        end

        @(negedge clk);
        req = 1'b0;
        #1;
        check("final_hits", hit_cnt, m_hits);
        check("final_misses", miss_cnt, m_misses);
        check("final_stall", stall, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_core_icache_nway.md
# riscv_core_icache_nway

Parametrised N-way set-associative instruction cache for the RV32IMC fetch stage. It combines tag/data storage and the controller in one block. It serves word fetches to the core in the same cycle on a hit and refills whole lines through the existing single-request AXI line-fetch handshake. It adds three things to the direct-mapped I-cache: per-set round-robin replacement, a `fence.i` full-invalidate walk, and hit/miss performance counters.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch/line address width
- CORE_DATA_WIDTH, 32, fetch word width; fixed at 32
- AXI_DATA_WIDTH, 256, line width in bits; power of two, ≥ 64
- NUM_SETS, 128, number of sets; power of two, ≥ 2
- NUM_WAYS, 2, associativity; power of two, 1..8
- Derived widths:
  - OFFSET_BITS = log2(AXI_DATA_WIDTH/8)
  - INDEX_BITS = log2(NUM_SETS)
  - TAG_BITS = ADDR_WIDTH − INDEX_BITS − OFFSET_BITS

Ports:
- i_clk  in  1  sole clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  core fetch valid
- i_addr_from_core  in  ADDR_WIDTH  fetch address; bits [1:0] ignored
- i_flush  in  1  fence.i pulse: invalidate whole cache
- o_stall  out  1  core must hold its fetch address
- o_data_to_core  out  32  fetched word; valid when i_req & ~o_stall
- o_addr_from_control_to_axi  out  ADDR_WIDTH  line-aligned refill address (offset bits zero)
- o_mem_req  out  1  refill request, level, registered
- i_mem_done  in  1  refill complete; line present on i_block_from_axi this cycle
- i_block_from_axi  in  AXI_DATA_WIDTH  refill line; word 0 = bits [31:0]
- o_hit_cnt  out  32  hits since reset, wraps
- o_miss_cnt  out  32  misses since reset, wraps

## Operation
- **Address split:** tag = addr[ADDR_WIDTH−1 : INDEX_BITS+OFFSET_BITS]; index = next INDEX_BITS; word select = addr[OFFSET_BITS−1:2].
- **Storage:** per set and way: valid bit, tag, and line. Per set: a log2(NUM_WAYS)-bit round-robin pointer (absent when NUM_WAYS = 1).
- **Lookup:** combinational.
  - Hit = some way has valid & tag match.
  - At most one way matches by construction.
  - o_data_to_core = selected word of the hitting way; 0 when no hit.
- **FSM states:** IDLE, REFILL, FLUSH.
- **IDLE:**
  - i_flush=1 → FLUSH. Flush has priority over a simultaneous request; no hit or miss is counted that cycle.
  - Else i_req & hit → serve the word; o_hit_cnt += 1.
  - Else i_req & miss → latch the line-aligned address and the index; choose the victim; o_miss_cnt += 1; → REFILL.
- **Victim choice:** the lowest-numbered invalid way in the set. If all ways are valid, the way named by the set's pointer.
- **REFILL:**
  - o_mem_req=1 and the address output is stable for the whole state.
  - On i_mem_done: write the line, tag and valid=1 into the victim way.
  - If the victim was the pointer way, the pointer advances by 1 mod NUM_WAYS.
  - Then → IDLE, or → FLUSH if a flush is pending.
- **Flush pending:** i_flush during REFILL sets a pending flag. The refill completes normally and FLUSH follows immediately.
- **FLUSH:**
  - A set counter runs 0..NUM_SETS−1.
  - Each cycle, clear all valid bits and the pointer of the counted set.
  - After the last set, → IDLE.
  - Further i_flush during FLUSH is ignored.
- **Ignored inputs:** i_mem_done outside REFILL. i_addr_from_core changes during REFILL do not affect the refill.
- **Replacement on hit:** a hit does not update the replacement pointer.

## Timing
- **o_stall (combinational):** = (state≠IDLE) | (state==IDLE & i_flush) | (state==IDLE & i_req & ~hit).
- **Hit latency:** 0 cycles. Data is valid in the same cycle as the address.
- **Miss at cycle T (IDLE):**
  - o_mem_req rises at T+1.
  - i_mem_done at cycle D ≥ T+1.
  - o_mem_req=0 at D+1, state IDLE, and the same address hits at D+1 with o_stall=0.
- **Flush:** i_flush in IDLE at cycle T → FLUSH occupies T+1..T+NUM_SETS → IDLE at T+NUM_SETS+1.
- **Reset (asynchronous assert, synchronous release):**
  - state=IDLE; all valid bits, pointers and counters = 0.
  - o_mem_req=0; o_addr_from_control_to_axi=0; pending flag = 0.
  - Outputs therefore follow: o_stall = i_req | i_flush; o_data_to_core = 0.
  - Reset during REFILL abandons the refill. No line is written, and o_mem_req drops asynchronously.
- **Counters:** at most +1 each per cycle; wrap from 0xFFFFFFFF to 0.

## Test plan
- **Cold miss:** reset, i_req=1, addr 0x0000_1004.
  - Expect o_stall=1 and the next cycle o_mem_req=1 with address 0x0000_1000.
  - Return done with a line whose word1 = 0xDEADBEEF.
  - The next cycle: o_stall=0, data 0xDEADBEEF, hit=1/miss=1.
- **Hit path:** after the cold miss, fetch 0x1000, 0x1008, 0x101C on consecutive cycles.
  - Expect zero stall cycles and words 0/2/7 of the line; o_hit_cnt += 3.
- **Conflict/round-robin (2-way, defaults):** fill 0x0000_1000, 0x0001_1000, 0x0002_1000 (same index).
  - The third refill evicts way 0 (0x1000).
  - Refetching 0x1000 misses and evicts way 1 (0x0001_1000); 0x0002_1000 still hits.
- **Flush:** with lines cached, pulse i_flush in IDLE.
  - Expect o_stall=1 for exactly 1+NUM_SETS cycles.
  - All previously cached addresses then miss.
- **Flush during refill:** pulse i_flush two cycles after o_mem_req rises.
  - The refill completes and FLUSH follows immediately.
  - The refilled address misses afterwards.
- **Reset mid-refill:** assert i_rst_n=0 while o_mem_req=1.
  - o_mem_req drops immediately and the counters read 0.
  - After release, the same address misses.
